// File: rtl/axis_switch_pkg.sv
// Shared definitions for the AXI-Stream switch mux/demux pair.
// State encodings and select-word validation live here so both directions agree.
package axis_switch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    // True when exactly one of the low n bits of v is set.
    function automatic logic onehot_ok(input logic [31:0] v, input int n);
        int ones;
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < n && v[i]) ones++;
        end
        return (ones == 1);
    endfunction

endpackage

// File: rtl/axis_switch_demux_if.sv
// Stream-side signals of the 1:NUM demux: one slave input stream and NUM master lanes.
interface axis_switch_demux_if #(
    parameter int NUM        = 2,
    parameter int DATA_WIDTH = 32
);
    logic                      s_axis_tvalid;
    logic                      s_axis_tready;
    logic [DATA_WIDTH-1:0]     s_axis_tdata;
    logic                      s_axis_tlast;
    logic [NUM-1:0]            m_axis_tvalid;
    logic [NUM-1:0]            m_axis_tready;
    logic [NUM*DATA_WIDTH-1:0] m_axis_tdata;
    logic [NUM-1:0]            m_axis_tlast;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer (main + skid register) with a registered input ready.
// Keeps full throughput while letting the downstream ready path stay off the input ready.
module axis_skid_buffer #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [W-1:0] main_q, main_d, skid_q, skid_d;
    logic         main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic         rdy_q, rdy_d;
    logic         acc, pop;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        acc        = in_valid & rdy_q;
        pop        = main_vld_q & out_ready;
        // acc can only be true while the skid slot is empty
        if (skid_vld_q) begin
            if (pop) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (acc) begin
            if (!main_vld_q || pop) begin
                main_d     = in_data;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = in_data;
                skid_vld_d = 1'b1;
            end
        end else if (pop) begin
            main_vld_d = 1'b0;
        end
        rdy_d = !skid_vld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = main_vld_q;
    assign out_data  = main_q;

endmodule

// File: rtl/axis_switch_demux.sv
// 1:NUM AXI-Stream packet demux: steers whole packets to the one-hot selected lane,
// drops packets with an invalid select and counts them in a saturating counter.
module axis_switch_demux
    import axis_switch_pkg::*;
#(
    parameter int NUM        = 2,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 s_axis_aclk,
    input  logic                 s_axis_aresetn,
    axis_switch_demux_if.slave   bus,
    input  logic [NUM-1:0]       position,
    output logic [CNT_WIDTH-1:0] drop_cnt
);
    // Each buffered beat carries its destination lane so a new packet can latch
    // a new select while the previous one is still draining.
    localparam int W = NUM + 1 + DATA_WIDTH;

    state_e                state_q, state_d;
    logic [NUM-1:0]        sel_q, sel_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  s_ready, accept, sel_ok, push, drop_last;
    logic                  buf_in_ready, buf_out_valid, buf_out_ready;
    logic [W-1:0]          buf_out_data;
    logic [NUM-1:0]        head_lane;
    logic                  head_last;
    logic [DATA_WIDTH-1:0] head_data;

    assign s_ready = buf_in_ready | (state_q == ST_DROP);
    assign accept  = bus.s_axis_tvalid & s_ready;
    assign sel_ok  = onehot_ok(32'(position), NUM);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        drop_last = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) begin
                if (sel_ok) begin
                    sel_d = position;
                    push  = 1'b1;
                    if (!bus.s_axis_tlast) state_d = ST_PASS;
                end else if (bus.s_axis_tlast) begin
                    drop_last = 1'b1;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_PASS: if (accept) begin
                push = 1'b1;
                if (bus.s_axis_tlast) state_d = ST_IDLE;
            end
            ST_DROP: if (accept && bus.s_axis_tlast) begin
                drop_last = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (drop_last && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    axis_skid_buffer #(.W(W)) u_skid (
        .clk       (s_axis_aclk),
        .rst_n     (s_axis_aresetn),
        .in_valid  (push),
        .in_ready  (buf_in_ready),
        .in_data   ({sel_d, bus.s_axis_tlast, bus.s_axis_tdata}),
        .out_valid (buf_out_valid),
        .out_ready (buf_out_ready),
        .out_data  (buf_out_data)
    );

    assign {head_lane, head_last, head_data} = buf_out_data;
    assign buf_out_ready = |(bus.m_axis_tready & head_lane);

    always_comb begin
        bus.m_axis_tvalid = '0;
        bus.m_axis_tlast  = '0;
        bus.m_axis_tdata  = '0;
        for (int k = 0; k < NUM; k++) begin
            if (buf_out_valid && head_lane[k]) begin
                bus.m_axis_tvalid[k]                           = 1'b1;
                bus.m_axis_tlast[k]                            = head_last;
                bus.m_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH]   = head_data;
            end
        end
    end

    assign bus.s_axis_tready = s_ready;
    assign drop_cnt          = cnt_q;

endmodule

// File: tb/tb_axis_switch_demux.sv
// Directed bench for axis_switch_demux: stimulus pushes expected lane beats into a
// scoreboard queue, a negedge monitor pops and compares every output transfer.
module tb_axis_switch_demux;
    localparam int NUM = 2;
    localparam int DW  = 32;
    localparam int CW  = 2;

    typedef struct {
        int          lane;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    position = 2'b00;
    logic [CW-1:0] drop_cnt;
    logic          rdy0 = 1'b1, rdy1 = 1'b1, tog_en = 1'b0, tog_q = 1'b0;
    exp_t          q[$];
    int            n_cmp = 0, n_err = 0, stalls = 0;

    axis_switch_demux_if #(.NUM(NUM), .DATA_WIDTH(DW)) bus ();

    axis_switch_demux #(.NUM(NUM), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .bus            (bus.slave),
        .position       (position),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tog_q <= ~tog_q;
    assign bus.m_axis_tready = {rdy1, tog_en ? tog_q : rdy0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            chk("single_lane_valid", 64'($countones(bus.m_axis_tvalid) <= 1), 64'd1);
            for (int k = 0; k < NUM; k++) begin
                if (!bus.m_axis_tvalid[k]) begin
                    chk("idle_lane_zero", {bus.m_axis_tdata[k*DW +: DW], 31'd0, bus.m_axis_tlast[k]}, 64'd0);
                end else if (bus.m_axis_tready[k]) begin
                    if (q.size() == 0) begin
                        chk("unexpected_beat", 64'(bus.m_axis_tdata[k*DW +: DW]), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("beat_lane", 64'(k), 64'(e.lane));
                        chk("beat_data", 64'(bus.m_axis_tdata[k*DW +: DW]), 64'(e.data));
                        chk("beat_last", 64'(bus.m_axis_tlast[k]), 64'(e.last));
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic last, input logic [1:0] pos, input int lane);
        int   n;
        logic r;
        if (lane >= 0) begin
            exp_t e;
            e.lane = lane; e.data = d; e.last = last;
            q.push_back(e);
        end
        position          = pos;
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = last;
        bus.s_axis_tvalid = 1'b1;
        n = 0;
        r = 1'b0;
        while (!r && n < 100) begin
            @(negedge clk);
            r = bus.s_axis_tready;
            @(posedge clk);
            n++;
            if (!r) stalls++;
        end
        if (!r) chk("accept_timeout", 64'd0, 64'd1);
        #1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    initial begin
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = 1'b0;
        #12;
        chk("rst_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        chk("rst_dropcnt", 64'(drop_cnt), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("tready_after_rst", 64'(bus.s_axis_tready), 64'd1);

        // 1: four beats to lane0 at full rate
        for (int i = 0; i < 4; i++) send(32'hA0 + 32'(i), i == 3, 2'b01, 0);
        chk("t1_no_stall", 64'(stalls), 64'd0);

        // 2: lane1 packet; position changes mid-packet are ignored
        send(32'hB0, 1'b0, 2'b10, 1);
        send(32'hB1, 1'b0, 2'b01, 1);
        send(32'hB2, 1'b1, 2'b01, 1);
        send(32'hB8, 1'b0, 2'b01, 0);
        send(32'hB9, 1'b1, 2'b01, 0);

        // 3: invalid selects are dropped and counted
        send(32'hC0, 1'b0, 2'b11, -1);
        send(32'hC1, 1'b1, 2'b11, -1);
        chk("t3_cnt1", 64'(drop_cnt), 64'd1);
        send(32'hC2, 1'b0, 2'b00, -1);
        send(32'hC3, 1'b1, 2'b00, -1);
        chk("t3_cnt2", 64'(drop_cnt), 64'd2);
        send(32'hD0, 1'b0, 2'b01, 0);
        send(32'hD1, 1'b1, 2'b01, 0);

        // 6: counter saturates at all-ones (CW=2 -> 3)
        send(32'hE0, 1'b1, 2'b00, -1);
        chk("t6_cnt3", 64'(drop_cnt), 64'd3);
        send(32'hE1, 1'b1, 2'b00, -1);
        chk("t6_sat_a", 64'(drop_cnt), 64'd3);
        send(32'hE2, 1'b1, 2'b00, -1);
        chk("t6_sat_b", 64'(drop_cnt), 64'd3);

        // 4: lane0 ready toggling under an 8-beat packet
        tog_en = 1'b1;
        for (int i = 0; i < 8; i++) send(32'hF0 + 32'(i), i == 7, 2'b01, 0);
        repeat (8) @(posedge clk);
        tog_en = 1'b0;
        #1;
        chk("t4_drained", 64'(q.size()), 64'd0);

        // 5: reset mid-packet with beats parked in the buffer
        rdy0 = 1'b0;
        send(32'h50, 1'b0, 2'b01, -1);
        send(32'h51, 1'b0, 2'b01, -1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        chk("t5_rst_tdata", 64'(bus.m_axis_tdata), 64'd0);
        chk("t5_rst_tlast", 64'(bus.m_axis_tlast), 64'd0);
        chk("t5_rst_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("t5_rst_dropcnt", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy0  = 1'b1;
        @(posedge clk); #1;
        send(32'h60, 1'b0, 2'b10, 1);
        send(32'h61, 1'b1, 2'b01, 1);

        repeat (10) @(posedge clk);
        #1;
        chk("final_queue_empty", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
